ps2_keyboard_rx: RTL and testbench

- Upstream input stage for the SBC top level. Receives scan-code bytes from a PS/2 keyboard on the clk_50m domain.
- Drives the `keyCode[7:0]` / `dataReady` pair consumed by the top level.
- Synchronises and deglitches the open-collector PS/2 lines, then deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Flags parity, framing and timeout errors.

---
 rtl/sbc_pkg.sv | 29 ++
 rtl/ps2_line_filter.sv | 55 +++++
 rtl/ps2_keyboard_rx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sbc_pkg.sv
// -----------------------------------------------------------------------------
// sbc_pkg
// Definitions shared by the SBC input stage: the PS/2 receiver state
// encoding, the special scan-code bytes, the frame geometry, and an
// odd-parity helper.
// No ports (package).
// -----------------------------------------------------------------------------
package sbc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
    localparam int         PS2_FRAME_BITS = 11;

    // start + parity + stop surround the data bits
    localparam int         PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

    // Odd parity: data bits and parity bit together hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// -----------------------------------------------------------------------------
// ps2_line_filter
// Brings an asynchronous open-collector PS/2 line into clk_50m, rejects
// glitches shorter than FILTER_LEN samples and flags the filtered 1->0
// transition.
// Ports:
//   clk_50m   in   system clock
//   rst_n     in   synchronous active-low reset
//   line_raw  in   raw asynchronous PS/2 line
//   fall      out  one-cycle pulse on the filtered falling edge
// -----------------------------------------------------------------------------
module ps2_line_filter
    import sbc_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic line_raw,
    output logic fall
);

    localparam int                CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             filt_q;
    logic             filt_d1_q;

    // The filtered level only moves after FILTER_LEN consecutive samples that
    // disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            filt_q    <= 1'b1;
            filt_d1_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], line_raw};
            filt_d1_q <= filt_q;
            if (sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                filt_q <= sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign fall = filt_d1_q & ~filt_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// -----------------------------------------------------------------------------
// ps2_keyboard_rx
// PS/2 keyboard receiver: deserialises 11-bit frames (start, 8 data bits
// LSB first, odd parity, stop) into scan-code bytes and flags parity,
// framing and mid-frame timeout errors. All outputs are registered; a
// result appears the cycle after the stop-bit edge is seen.
// Optional build macro PS2_BREAK_FILTER_EN: absorbs F0/E0 prefix bytes
// and reports them through is_break/is_ext on the following byte.
// Ports:
//   clk_50m     in   50 MHz system clock
//   rst_n       in   synchronous active-low reset
//   ps2_clk     in   raw PS/2 clock
//   ps2_data    in   raw PS/2 data
//   keyCode     out  last received scan code, held between frames
//   dataReady   out  one-cycle pulse, keyCode valid
//   is_break    out  release code flag, valid with dataReady
//   is_ext      out  E0-prefixed flag, valid with dataReady
//   parity_err  out  one-cycle pulse, parity check failed
//   frame_err   out  one-cycle pulse, bad start/stop bit or timeout
// -----------------------------------------------------------------------------
// state  | meaning
// IDLE   | waiting for a start bit
// DATA   | shifting in the 8 data bits
// PARITY | waiting for the parity bit
// STOP   | waiting for the stop bit, then report
module ps2_keyboard_rx
    import sbc_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyCode,
    output logic       dataReady,
    output logic       is_break,
    output logic       is_ext,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]       BIT_LAST = 3'(PS2_DATA_BITS - 1);

    ps2_state_t       state_q, state_nxt;
    logic [2:0]       bit_cnt_q, bit_cnt_nxt;
    logic [7:0]       shift_q, shift_nxt;
    logic             par_q, par_nxt;
    logic [TMO_W-1:0] tmo_q, tmo_nxt;
    logic             ev_ok, ev_perr, ev_ferr;

    logic             clk_fall;
    logic [1:0]       data_sync_q;
    logic             data_bit;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .line_raw (ps2_clk),
        .fall     (clk_fall)
    );

    // Data is held stable for the whole clock-low phase, so a plain
    // synchroniser suffices; it is sampled when the filtered clock falls.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) data_sync_q <= 2'b11;
        else        data_sync_q <= {data_sync_q[0], ps2_data};
    end
    assign data_bit = data_sync_q[1];

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_nxt;
            bit_cnt_q <= bit_cnt_nxt;
            shift_q   <= shift_nxt;
            par_q     <= par_nxt;
            tmo_q     <= tmo_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        bit_cnt_nxt = bit_cnt_q;
        shift_nxt   = shift_q;
        par_nxt     = par_q;
        tmo_nxt     = tmo_q;
        ev_ok       = 1'b0;
        ev_perr     = 1'b0;
        ev_ferr     = 1'b0;
        if (state_q == IDLE) begin
            tmo_nxt = '0;
            if (clk_fall) begin
                if (!data_bit) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                end else begin
                    ev_ferr = 1'b1;
                end
            end
        end else if (clk_fall) begin
            tmo_nxt = '0;
            unique case (state_q)
                DATA: begin
                    shift_nxt   = {data_bit, shift_q[7:1]};
                    bit_cnt_nxt = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == BIT_LAST) state_nxt = PARITY;
                end
                PARITY: begin
                    par_nxt   = data_bit;
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    // a bad stop bit outranks a parity failure
                    if (!data_bit)                          ev_ferr = 1'b1;
                    else if (!odd_parity_ok(shift_q, par_q)) ev_perr = 1'b1;
                    else                                    ev_ok   = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (tmo_q == TMO_LAST) begin
            state_nxt = IDLE;
            tmo_nxt   = '0;
            shift_nxt = '0;
            ev_ferr   = 1'b1;
        end else begin
            tmo_nxt = tmo_q + 1'b1;
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    logic brk_flag_q;
    logic ext_flag_q;

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            keyCode    <= 8'h00;
            dataReady  <= 1'b0;
            is_break   <= 1'b0;
            is_ext     <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            brk_flag_q <= 1'b0;
            ext_flag_q <= 1'b0;
        end else begin
            dataReady  <= 1'b0;
            is_break   <= 1'b0;
            is_ext     <= 1'b0;
            parity_err <= ev_perr;
            frame_err  <= ev_ferr;
            if (ev_perr || ev_ferr) begin
                brk_flag_q <= 1'b0;
                ext_flag_q <= 1'b0;
            end else if (ev_ok) begin
                if (shift_q == PS2_BREAK_CODE) begin
                    brk_flag_q <= 1'b1;
                end else if (shift_q == PS2_EXT_CODE) begin
                    ext_flag_q <= 1'b1;
                end else begin
                    keyCode    <= shift_q;
                    dataReady  <= 1'b1;
                    is_break   <= brk_flag_q;
                    is_ext     <= ext_flag_q;
                    brk_flag_q <= 1'b0;
                    ext_flag_q <= 1'b0;
                end
            end
        end
    end
`else
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            keyCode    <= 8'h00;
            dataReady  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            dataReady  <= ev_ok;
            parity_err <= ev_perr;
            frame_err  <= ev_ferr;
            if (ev_ok) keyCode <= shift_q;
        end
    end

    assign is_break = 1'b0;
    assign is_ext   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_keyboard_rx
// Drives PS/2 frames into ps2_keyboard_rx and compares every output pulse
// against an event-level model of the keyboard protocol. The PS/2 clock and
// the timeout are scaled down to keep the run short.
// -----------------------------------------------------------------------------
module tb_ps2_keyboard_rx;

    localparam int FL   = 8;
    localparam int TO   = 1000;
    localparam int HALF = 40;

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keyCode;
    logic       dataReady, is_break, is_ext, parity_err, frame_err;

    always #10 clk_50m = ~clk_50m;

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .keyCode    (keyCode),
        .dataReady  (dataReady),
        .is_break   (is_break),
        .is_ext     (is_ext),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    // event: kind 0 = overlapping pulses, 1 = data, 2 = parity error, 3 = frame error
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_kc   = 8'h00;
    bit         m_brk  = 1'b0;
    bit         m_ext  = 1'b0;

    always @(negedge clk_50m) begin
        int  n;
        ev_t e;
        n = int'(dataReady) + int'(parity_err) + int'(frame_err);
        if (n > 1) begin
            e = {2'd0, 8'h00, 1'b0, 1'b0};
            obs_q.push_back(e);
        end else if (dataReady) begin
            e = {2'd1, keyCode, is_break, is_ext};
            obs_q.push_back(e);
        end else if (parity_err) begin
            e = {2'd2, 8'h00, 1'b0, 1'b0};
            obs_q.push_back(e);
        end else if (frame_err) begin
            e = {2'd3, 8'h00, 1'b0, 1'b0};
            obs_q.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic [7:0] code, input bit brk, input bit ext);
        ev_t e;
        e = {kind, code, brk, ext};
        exp_q.push_back(e);
    endtask

    // Protocol-level view of one received frame.
    task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        if (bad_stop) begin
            push_exp(2'd3, 8'h00, 1'b0, 1'b0);
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (bad_par) begin
            push_exp(2'd2, 8'h00, 1'b0, 1'b0);
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else begin
`ifdef PS2_BREAK_FILTER_EN
            if (d == 8'hF0)      m_brk = 1'b1;
            else if (d == 8'hE0) m_ext = 1'b1;
            else begin
                push_exp(2'd1, d, m_brk, m_ext);
                m_kc  = d;
                m_brk = 1'b0;
                m_ext = 1'b0;
            end
`else
            push_exp(2'd1, d, 1'b0, 1'b0);
            m_kc = d;
`endif
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic p;
        p = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
        return {~bad_stop, p ^ bad_par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            cyc(HALF);
            ps2_clk = 1'b0;
            cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        send_bits(frame_bits(d, bad_par, bad_stop), 11);
        model_frame(d, bad_par, bad_stop);
        cyc(2 * HALF);
    endtask

    task automatic compare_events(input string tag);
        int n;
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_ev%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        chk({tag, "_keycode"}, 32'(keyCode), 32'(m_kc));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [10:0] bits;
        logic        dr_seen [1:14];

        rst_n = 1'b0;
        cyc(5);
        chk("rst_keycode",    32'(keyCode),    32'h00);
        chk("rst_dataready",  32'(dataReady),  32'h0);
        chk("rst_parity_err", 32'(parity_err), 32'h0);
        chk("rst_frame_err",  32'(frame_err),  32'h0);
        chk("rst_is_break",   32'(is_break),   32'h0);
        chk("rst_is_ext",     32'(is_ext),     32'h0);
        rst_n = 1'b1;
        cyc(20);
        obs_q.delete();

        // 0x1C with exact latency: dataReady for one cycle, one cycle after
        // the filtered stop edge (2 sync + FL filter samples + 1 register).
        bits = frame_bits(8'h1C, 1'b0, 1'b0);
        send_bits(bits, 10);
        ps2_data = 1'b1;
        cyc(HALF);
        ps2_clk = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk_50m);
            @(negedge clk_50m);
            dr_seen[k] = dataReady;
        end
        chk("lat_before", 32'(dr_seen[2 + FL]), 32'h0);
        chk("lat_at",     32'(dr_seen[3 + FL]), 32'h1);
        chk("lat_after",  32'(dr_seen[4 + FL]), 32'h0);
        cyc(HALF - 14);
        ps2_clk = 1'b1;
        model_frame(8'h1C, 1'b0, 1'b0);
        cyc(2 * HALF);
        compare_events("good_1c");

        send_frame(8'h1C, 1'b1, 1'b0);
        compare_events("bad_parity");

        send_frame(8'h29, 1'b0, 1'b1);
        send_frame(8'h29, 1'b0, 1'b0);
        compare_events("bad_stop");

        // start + 5 data bits, then the clock stays high past the timeout
        send_bits(frame_bits(8'h5A, 1'b0, 1'b0), 6);
        cyc(TO + TO / 2);
        push_exp(2'd3, 8'h00, 1'b0, 1'b0);
        m_brk = 1'b0;
        m_ext = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0);
        compare_events("timeout");

        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        compare_events("break_seq");
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        compare_events("ext_break_seq");

        // reset after the 4th data bit discards the partial frame
        send_bits(frame_bits(8'h33, 1'b0, 1'b0), 5);
        cyc(5);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        m_kc  = 8'h00;
        m_brk = 1'b0;
        m_ext = 1'b0;
        chk("midreset_keycode", 32'(keyCode), 32'h00);
        cyc(50);
        send_frame(8'h1C, 1'b0, 1'b0);
        compare_events("midreset");

        // short clock glitches must never reach the frame logic
        for (int g = 0; g < 6; g++) begin
            ps2_data = 1'($urandom_range(0, 1));
            cyc(5);
            ps2_clk = 1'b0;
            cyc(3);
            ps2_clk = 1'b1;
            cyc(20);
        end
        ps2_data = 1'b1;
        cyc(TO + 100);
        compare_events("glitch");

        // random back-to-back frames
        for (int r = 0; r < 16; r++) begin
            logic [7:0] d;
            bit         bp, bs;
            d  = 8'($urandom);
            bp = ($urandom_range(0, 5) == 0);
            bs = ($urandom_range(0, 5) == 0);
            send_frame(d, bp, bs);
        end
        compare_events("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
